// File: rtl/snes_input_arbiter.sv
// snes_input_arbiter: shares the SNES button interface between a decoded IR
// remote word and a wired pad. It selects an owner with an IDLE/PAD/IR machine,
// stretches IR words over a hold window, and serves the arbitrated word to the
// console over the SNES latch/clock/data serial protocol.
// Optional feature macro: PAD_PREEMPT_EN (a nonzero pad in IR forces PAD).
module snes_input_arbiter #(
    parameter int unsigned HOLD_CYCLES    = 240000,
    parameter int unsigned RELEASE_CYCLES = 2000
) (
    input  logic        osc_clk,
    input  logic        reset,
    input  logic        ir_valid,
    input  logic [15:0] ir_buttons,
    input  logic [15:0] pad_buttons,
    input  logic        snes_latch,
    input  logic        snes_clk,
    output logic        snes_data,
    output logic [15:0] buttons,
    output logic [1:0]  owner,
    output logic        ir_hold_active
);

    localparam int unsigned BTN_W  = 16;
    localparam int unsigned HOLD_W = 18;
    localparam int unsigned REL_W  = 11;

    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [REL_W-1:0]  REL_LAST  = REL_W'(RELEASE_CYCLES - 1);

`ifdef PAD_PREEMPT_EN
    localparam logic PREEMPT = 1'b1;
`else
    localparam logic PREEMPT = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PAD  = 2'b01,
        ST_IR   = 2'b10
    } state_e;

    state_e             state_q, state_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [REL_W-1:0]   rel_q, rel_d;
    logic [BTN_W-1:0]   word_q, word_d;
    logic [BTN_W-1:0]   buttons_q, buttons_d;
    logic               hold_active_q, hold_active_d;

    logic               pad_active;
    logic               ir_new;
    logic               ir_release;

    assign pad_active = |pad_buttons;
    assign ir_new     = ir_valid & (|ir_buttons);
    assign ir_release = ir_valid & ~(|ir_buttons);

    // Ownership machine: next state, counters, latched IR word and outputs.
    always_comb begin
        state_d       = state_q;
        hold_d        = hold_q;
        rel_d         = rel_q;
        word_d        = word_q;
        buttons_d     = '0;
        hold_active_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Pad wins a same-cycle tie; the IR word is dropped.
                if (pad_active) begin
                    state_d = ST_PAD;
                    rel_d   = '0;
                end else if (ir_new) begin
                    state_d = ST_IR;
                    word_d  = ir_buttons;
                    hold_d  = HOLD_LOAD;
                end
            end
            ST_PAD: begin
                if (pad_active) begin
                    rel_d = '0;
                end else if (rel_q == REL_LAST) begin
                    state_d = ST_IDLE;
                    rel_d   = '0;
                end else begin
                    rel_d = rel_q + REL_W'(1);
                end
            end
            ST_IR: begin
                if (PREEMPT && pad_active) begin
                    state_d = ST_PAD;
                    rel_d   = '0;
                    hold_d  = '0;
                end else if (ir_release) begin
                    state_d = ST_IDLE;
                    hold_d  = '0;
                end else if (ir_new) begin
                    word_d = ir_buttons;
                    hold_d = HOLD_LOAD;
                end else if (hold_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                hold_d  = '0;
                rel_d   = '0;
            end
        endcase

        case (state_d)
            ST_PAD:  buttons_d = pad_buttons;
            ST_IR:   buttons_d = word_d;
            default: buttons_d = '0;
        endcase
        hold_active_d = (state_d == ST_IR) && (hold_d != '0);
    end

    // Ownership machine registers and registered arbiter outputs.
    always_ff @(posedge osc_clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            hold_q        <= '0;
            rel_q         <= '0;
            word_q        <= '0;
            buttons_q     <= '0;
            hold_active_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_q        <= hold_d;
            rel_q         <= rel_d;
            word_q        <= word_d;
            buttons_q     <= buttons_d;
            hold_active_q <= hold_active_d;
        end
    end

    assign buttons        = buttons_q;
    assign owner          = state_q;
    assign ir_hold_active = hold_active_q;

    // Serial port: console strobes are synchronized, then edge detected.
    logic               latch_s1_q, latch_s2_q, latch_h_q;
    logic               clk_s1_q, clk_s2_q, clk_h_q;
    logic [BTN_W-1:0]   shift_q, shift_d;
    logic               snes_data_q, snes_data_d;
    logic               latch_rise;
    logic               clk_rise;

    assign latch_rise = latch_s2_q & ~latch_h_q;
    assign clk_rise   = clk_s2_q & ~clk_h_q;

    // Shift register: load on latch rise, keep reloading while latch is high,
    // shift right on each console clock rise; zeros fill in after 16 bits.
    always_comb begin
        shift_d = shift_q;
        if (latch_rise) begin
            shift_d = buttons_q;
        end else if (latch_s2_q) begin
            shift_d = buttons_q;
        end else if (clk_rise) begin
            shift_d = {1'b0, shift_q[BTN_W-1:1]};
        end
        snes_data_d = ~shift_d[0];
    end

    // Synchronizer, history and shift register flops.
    always_ff @(posedge osc_clk) begin
        if (reset) begin
            latch_s1_q  <= 1'b0;
            latch_s2_q  <= 1'b0;
            latch_h_q   <= 1'b0;
            clk_s1_q    <= 1'b1;
            clk_s2_q    <= 1'b1;
            clk_h_q     <= 1'b1;
            shift_q     <= '0;
            snes_data_q <= 1'b1;
        end else begin
            latch_s1_q  <= snes_latch;
            latch_s2_q  <= latch_s1_q;
            latch_h_q   <= latch_s2_q;
            clk_s1_q    <= snes_clk;
            clk_s2_q    <= clk_s1_q;
            clk_h_q     <= clk_s2_q;
            shift_q     <= shift_d;
            snes_data_q <= snes_data_d;
        end
    end

    assign snes_data = snes_data_q;

endmodule
